// File: rtl/vector_response_checker_if.sv
`default_nettype none
//==============================================================================
// Module : vector_response_checker_if
// Desc   : Load, run-control, sample and result signals of the response checker.
// Rev    : 1.0  initial release
//==============================================================================
interface vector_response_checker_if #(
   parameter int WIDTH = 4,
   parameter int IDX_W = 7,
   parameter int ERR_W = 8
);
   logic                 LOAD_EN;
   logic [IDX_W-1:0]     LOAD_ADDR;
   logic [2*WIDTH-1:0]   LOAD_DATA;
   logic                 START;
   logic                 SAMPLE;
   logic [WIDTH-1:0]     Q;
   logic                 BUSY;
   logic                 DONE;
   logic                 PASS;
   logic [ERR_W-1:0]     ERR_CNT;
   logic                 FIRST_ERR_VALID;
   logic [IDX_W-1:0]     FIRST_ERR_IDX;
   logic [IDX_W-1:0]     CUR_IDX;

   modport master (
      output LOAD_EN, LOAD_ADDR, LOAD_DATA, START, SAMPLE, Q,
      input  BUSY, DONE, PASS, ERR_CNT, FIRST_ERR_VALID, FIRST_ERR_IDX, CUR_IDX
   );

   modport slave (
      input  LOAD_EN, LOAD_ADDR, LOAD_DATA, START, SAMPLE, Q,
      output BUSY, DONE, PASS, ERR_CNT, FIRST_ERR_VALID, FIRST_ERR_IDX, CUR_IDX
   );
endinterface
`default_nettype wire

// File: rtl/vector_response_checker.sv
`default_nettype none
//==============================================================================
// Module : vector_response_checker
// Desc   : Compares a sampled DUT output bus against a masked expected-value
//          table and reports mismatch count, first failing index and pass/fail.
// Rev    : 1.0  initial release
//==============================================================================
module vector_response_checker #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 100,
   parameter int IDX_W = 7,
   parameter int ERR_W = 8
) (
   input  wire logic                 CLK,
   input  wire logic                 RST,
   vector_response_checker_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W:0]   c_depth    = (IDX_W+1)'(DEPTH);
   localparam logic [ERR_W-1:0] c_err_max  = {ERR_W{1'b1}};

   state_t               r_state;
   state_t               w_state_nxt;

   logic [2*WIDTH-1:0]   r_table [0:DEPTH-1];

   logic [IDX_W-1:0]     r_cur_idx;
   logic                 r_last_taken;
   logic                 r_stg_valid;
   logic                 r_stg_last;
   logic [WIDTH-1:0]     r_stg_q;
   logic [2*WIDTH-1:0]   r_stg_entry;
   logic [IDX_W-1:0]     r_stg_idx;
   logic [ERR_W-1:0]     r_err_cnt;
   logic                 r_first_err_valid;
   logic [IDX_W-1:0]     r_first_err_idx;
   logic                 r_pass;

   logic                 w_start;
   logic                 w_accept;
   logic                 w_finish;
   logic                 w_load;
   logic                 w_mismatch;
   logic [WIDTH-1:0]     w_stg_mask;
   logic [WIDTH-1:0]     w_stg_exp;

   assign w_stg_mask = r_stg_entry[2*WIDTH-1:WIDTH];
   assign w_stg_exp  = r_stg_entry[WIDTH-1:0];

   // Only bits selected by the mask take part in the compare.
   assign w_mismatch = r_stg_valid && (|((r_stg_q ^ w_stg_exp) & w_stg_mask));

   assign w_start  = bus.START && (r_state != S_RUN);
   assign w_accept = (r_state == S_RUN) && bus.SAMPLE && !r_last_taken;
   assign w_finish = (r_state == S_RUN) && r_stg_valid && r_stg_last;
   assign w_load   = bus.LOAD_EN && (r_state != S_RUN) &&
                     ({1'b0, bus.LOAD_ADDR} < c_depth);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.START) w_state_nxt = S_RUN;
         S_RUN:   if (w_finish)  w_state_nxt = S_DONE;
         S_DONE:  if (bus.START) w_state_nxt = S_RUN;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Table storage is deliberately outside the reset domain so a mid-run
   // reset keeps the loaded vectors.
   always_ff @(posedge CLK) begin
      if (w_load) begin
         r_table[bus.LOAD_ADDR] <= bus.LOAD_DATA;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_cur_idx         <= '0;
         r_last_taken      <= 1'b0;
         r_stg_valid       <= 1'b0;
         r_stg_last        <= 1'b0;
         r_stg_q           <= '0;
         r_stg_entry       <= '0;
         r_stg_idx         <= '0;
         r_err_cnt         <= '0;
         r_first_err_valid <= 1'b0;
         r_first_err_idx   <= '0;
         r_pass            <= 1'b0;
      end else begin
         r_stg_valid <= w_accept;
         if (w_accept) begin
            r_stg_q     <= bus.Q;
            r_stg_entry <= r_table[r_cur_idx];
            r_stg_idx   <= r_cur_idx;
            r_stg_last  <= (r_cur_idx == c_last_idx);
            if (r_cur_idx == c_last_idx) begin
               r_last_taken <= 1'b1;
            end else begin
               r_cur_idx <= r_cur_idx + IDX_W'(1);
            end
         end

         if (w_start) begin
            r_cur_idx         <= '0;
            r_last_taken      <= 1'b0;
            r_err_cnt         <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_idx   <= '0;
            r_pass            <= 1'b0;
         end else if (w_mismatch && (r_state == S_RUN)) begin
            if (r_err_cnt != c_err_max) begin
               r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
            if (!r_first_err_valid) begin
               r_first_err_valid <= 1'b1;
               r_first_err_idx   <= r_stg_idx;
            end
         end

         // The last compare is resolved on this same edge, so fold it in.
         if (w_finish) begin
            r_pass <= (r_err_cnt == '0) && !w_mismatch;
         end
      end
   end

   assign bus.BUSY            = (r_state == S_RUN);
   assign bus.DONE            = (r_state == S_DONE);
   assign bus.PASS            = r_pass;
   assign bus.ERR_CNT         = r_err_cnt;
   assign bus.FIRST_ERR_VALID = r_first_err_valid;
   assign bus.FIRST_ERR_IDX   = r_first_err_idx;
   assign bus.CUR_IDX         = r_cur_idx;

endmodule
`default_nettype wire

// File: doc/vector_response_checker.md
Name: vector_response_checker

Overview:
- Synthesizable response checker: the receive-side counterpart of the vector-driving stimulus flow.
- Holds a table of expected DUT output values, each with a per-bit compare mask.
- Compares the DUT output bus Q on every SAMPLE strobe, in index order, against the table.
- Reports mismatch count, first failing index and pass/fail, so a run_map test design self-checks on hardware with no file logging.

Parameters:
- WIDTH, 4, width of the DUT output Q.
- DEPTH, 100, number of expected vectors per run; legal range 2..2**IDX_W.
- IDX_W, 7, width of vector index and load address.
- ERR_W, 8, width of mismatch counter; the counter saturates.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- LOAD_EN  input  1  write strobe for the expected table.
- LOAD_ADDR  input  IDX_W  table entry index, 0..DEPTH-1.
- LOAD_DATA  input  2*WIDTH  entry data: {MASK[WIDTH-1:0], EXP[WIDTH-1:0]}; MASK bit 1 = compare that bit.
- START  input  1  one-cycle pulse that begins a run.
- SAMPLE  input  1  Q is valid this cycle; consume one vector.
- Q  input  WIDTH  DUT output under check.
- BUSY  output  1  high while in RUN.
- DONE  output  1  high in DONE until the next START or reset.
- PASS  output  1  valid when DONE=1; 1 = zero mismatches.
- ERR_CNT  output  ERR_W  number of mismatching vectors, saturating at all-ones.
- FIRST_ERR_VALID  output  1  at least one mismatch has occurred.
- FIRST_ERR_IDX  output  IDX_W  index of the first mismatching vector.
- CUR_IDX  output  IDX_W  index of the next vector to be consumed.

Behaviour:
- Reset (async, RST=1): state IDLE.
  - BUSY=0, DONE=0, PASS=0, ERR_CNT=0.
  - FIRST_ERR_VALID=0, FIRST_ERR_IDX=0, CUR_IDX=0.
  - Table contents are not reset; they are undefined until loaded.
- Table: DEPTH x 2*WIDTH registers.
  - Written on the CLK edge when LOAD_EN=1, state is IDLE or DONE, and LOAD_ADDR<DEPTH.
  - All other writes are ignored: LOAD_EN during RUN, or LOAD_ADDR>=DEPTH.
- FSM states: IDLE, RUN, DONE.
  - IDLE --START--> RUN.
  - RUN --last compare consumed--> DONE.
  - DONE --START--> RUN.
  - START while in RUN is ignored.
- On entry to RUN: ERR_CNT, FIRST_ERR_VALID, FIRST_ERR_IDX, CUR_IDX cleared; PASS=0; DONE=0; BUSY=1 the cycle after the START edge.
- SAMPLE in the START cycle, in IDLE or in DONE: ignored.
- Compare pipeline in RUN, one stage:
  - Edge k, SAMPLE=1: register Q, entry[CUR_IDX] and CUR_IDX into the stage; CUR_IDX increments.
  - Edge k+1: mismatch = |((Q_r ^ EXP_r) & MASK_r).
    - On mismatch: ERR_CNT increments unless it is all-ones.
    - If FIRST_ERR_VALID=0, set FIRST_ERR_IDX=idx_r and FIRST_ERR_VALID=1.
  - Result latency: 1 cycle after the SAMPLE edge.
  - Back-to-back SAMPLE every cycle is fully supported.
- Run end:
  - When the sample with index DEPTH-1 is accepted, further SAMPLE is ignored; CUR_IDX holds at DEPTH-1.
  - The state moves to DONE on the edge that evaluates that last compare.
  - On that edge: BUSY=0, DONE=1, PASS = (final ERR_CNT==0).
- MASK=0 entry: always matches; Q is not checked.
- Simultaneous LOAD_EN and START in DONE: the write lands and the run starts on the same edge, so the written entry is visible to the first compare.
- RST asserted mid-run: immediate return to IDLE with all outputs at reset values; the table is retained.
- Outputs are registered only; there are no combinational paths from inputs to outputs.

Test Plan:
- Load 100 entries with MASK=4'hF and EXP=i[3:0], START, 100 SAMPLEs back-to-back with Q=i[3:0] -> DONE one cycle after the last SAMPLE, PASS=1, ERR_CNT=0, FIRST_ERR_VALID=0.
- Same load, Q wrong at indices 17 and 63 -> ERR_CNT=2, FIRST_ERR_IDX=17, FIRST_ERR_VALID=1, PASS=0.
- Entry 5 = MASK 4'b0011, EXP 4'b0001; Q=4'b1101 at index 5 -> no mismatch. Then Q=4'b1100 at index 5 -> ERR_CNT=1, FIRST_ERR_IDX=5.
- ERR_W=2, every vector wrong -> ERR_CNT saturates at 3, FIRST_ERR_IDX=0.
- SAMPLE gapped every 3rd cycle, START and LOAD_EN pulsed mid-run -> results identical to back-to-back; the table is unchanged.
- RST pulsed after 40 samples -> all outputs 0 within the reset cycle. A new START plus 100 good samples -> PASS=1 with no reload.
